// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the SPI stream bridge: core register map, FSM encoding,
// and the packed register-port bundle with its constructors.
package spi_bridge_pkg;

    localparam logic [2:0] SPI_ADDR_RXDATA  = 3'd0;
    localparam logic [2:0] SPI_ADDR_TXDATA  = 3'd1;
    localparam logic [2:0] SPI_ADDR_STATUS  = 3'd2;
    localparam logic [2:0] SPI_ADDR_CONTROL = 3'd3;
    localparam logic [2:0] SPI_ADDR_SSEL    = 3'd5;
    localparam logic [2:0] SPI_ADDR_EOPVAL  = 3'd6;

    typedef enum logic [2:0] {
        ST_INIT1, ST_INIT2, ST_IDLE, ST_WR1, ST_WR2, ST_RD1, ST_RD2, ST_GAP
    } state_t;

    typedef struct packed {
        logic        sel;
        logic [2:0]  addr;
        logic        read_n;
        logic        write_n;
        logic [15:0] data;
    } spi_bus_t;

    localparam spi_bus_t BUS_IDLE = '{sel: 1'b0, addr: 3'd0, read_n: 1'b1,
                                      write_n: 1'b1, data: 16'h0000};

    function automatic spi_bus_t bus_write(input logic [2:0] addr, input logic [15:0] data);
        bus_write = '{sel: 1'b1, addr: addr, read_n: 1'b1, write_n: 1'b0, data: data};
    endfunction

    function automatic spi_bus_t bus_read(input logic [2:0] addr);
        bus_read = '{sel: 1'b1, addr: addr, read_n: 1'b0, write_n: 1'b1, data: 16'h0000};
    endfunction

endpackage

// File: rtl/spi_bridge_rx_fifo.sv
// Synchronous RX FIFO with a registered head: rx_data/rx_valid come straight
// from flops and update on the edge that pushes into empty or pops.
module spi_bridge_rx_fifo #(
    parameter int DATA_W   = 8,
    parameter int RX_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              full
);

    localparam int PTR_W = $clog2(RX_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(RX_DEPTH);
    localparam logic [PTR_W:0] ONE_C   = (PTR_W + 1)'(1);

    logic [DATA_W-1:0] mem [RX_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_next;
    logic [PTR_W:0]    count, count_nxt;
    logic              do_push, do_pop;

    assign full      = (count == DEPTH_C);
    assign do_pop    = pop & (count != '0);
    assign do_push   = push & ~full;
    assign rd_next   = rd_ptr + 1'b1;
    assign count_nxt = count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_next;
            count    <= count_nxt;
            rx_valid <= (count_nxt != '0);
            // Head follows the next stored entry, or takes the incoming byte when
            // the FIFO would otherwise be left with nothing older to present.
            if (do_pop && count > ONE_C)
                rx_data <= mem[rd_next];
            else if (do_push && (count == '0 || do_pop))
                rx_data <= push_data;
        end
    end

endmodule

// File: rtl/spi_stream_bridge.sv
// Stream front end for the 8-bit SPI master core: arbitrates RX drain and TX
// writes onto the core's register port using fixed two-cycle accesses.
module spi_stream_bridge
    import spi_bridge_pkg::*;
#(
    parameter int          DATA_W   = 8,
    parameter int          RX_DEPTH = 4,
    parameter logic [15:0] SS_MASK  = 16'h0001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic              spi_select,
    output logic [2:0]        spi_mem_addr,
    output logic              spi_read_n,
    output logic              spi_write_n,
    output logic [15:0]       spi_data_from_cpu,
    input  logic [15:0]       spi_data_to_cpu,
    input  logic              spi_dataavailable,
    input  logic              spi_readyfordata
);

    state_t   state;
    spi_bus_t bus;
    logic     fifo_full, rd_go, wr_go, push;
    logic     unused_hi;

    assign unused_hi = ^spi_data_to_cpu[15:DATA_W];

    // Reads win so the core's receive register is drained before it can overrun.
    assign rd_go    = spi_dataavailable & ~fifo_full;
    assign wr_go    = ~rd_go & spi_readyfordata & tx_valid;
    assign tx_ready = (state == ST_IDLE) & ~rd_go & spi_readyfordata;
    assign push     = (state == ST_RD2);

    assign spi_select        = bus.sel;
    assign spi_mem_addr      = bus.addr;
    assign spi_read_n        = bus.read_n;
    assign spi_write_n       = bus.write_n;
    assign spi_data_from_cpu = bus.data;

    // The bus register is loaded on entry to the first access cycle and cleared
    // leaving the second; its data field doubles as the TX holding register.
    // The init write uses WR2 as its second cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT1;
            busy  <= 1'b1;
            bus   <= BUS_IDLE;
        end else begin
            case (state)
                ST_INIT1: begin
                    bus   <= bus_write(SPI_ADDR_SSEL, SS_MASK);
                    state <= ST_INIT2;
                end
                ST_INIT2: state <= ST_WR2;
                ST_IDLE: begin
                    if (rd_go) begin
                        bus   <= bus_read(SPI_ADDR_RXDATA);
                        busy  <= 1'b1;
                        state <= ST_RD1;
                    end else if (wr_go) begin
                        bus   <= bus_write(SPI_ADDR_TXDATA, {{(16 - DATA_W){1'b0}}, tx_data});
                        busy  <= 1'b1;
                        state <= ST_WR1;
                    end
                end
                ST_WR1: state <= ST_WR2;
                ST_RD1: state <= ST_RD2;
                ST_WR2, ST_RD2: begin
                    bus   <= BUS_IDLE;
                    state <= ST_GAP;
                end
                ST_GAP: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_INIT1;
            endcase
        end
    end

    spi_bridge_rx_fifo #(
        .DATA_W   (DATA_W),
        .RX_DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (spi_data_to_cpu[DATA_W-1:0]),
        .pop       (rx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .full      (fifo_full)
    );

endmodule
